hit_histogram: RTL and testbench

HIT_HISTOGRAM -- requirements
Module: hit_histogram

---
 rtl/hit_histogram.sv | 152 +++++++++++++++
 tb/tb_hit_histogram.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_histogram.sv
// Per-channel hit counter with a run FSM: counts hits until a threshold or a
// time window ends, dumps every channel into a FIFO, and serves it over a read bus.
module hit_histogram #(
  parameter logic [7:0]  MYAD   = 8'hC4,
  parameter int          NCH    = 32,
  parameter int          CW     = 16,
  parameter logic [15:0] MAXCNT = 16'hFFFF,
  parameter int          WINDOW = 1000,
  parameter int          FDEPTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           mode,
  input  logic [NCH-1:0] hit,
  input  logic [7:0]     Address,
  input  logic           Read,
  output logic [31:0]    DataOut,
  output logic           ack,
  output logic           busy,
  output logic           done
);

  localparam int             AW     = $clog2(FDEPTH);
  localparam int             CHW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]  CMAX   = '1;
  localparam logic [CW-1:0]  STOPV  = CW'(MAXCNT);
  localparam logic [23:0]    WIN    = 24'(WINDOW);
  localparam logic [CHW-1:0] LASTCH = CHW'(NCH - 1);
  localparam logic [AW:0]    FULLV  = (AW + 1)'(FDEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, DUMP, DRAIN} state_t;

  state_t          state_reg;
  logic            mode_reg;
  logic [23:0]     timer_reg;
  logic [CHW-1:0]  ch_reg;
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic            req_d_reg;
  logic            ack_reg;
  logic            done_reg;
  logic [31:0]     word_reg;
  logic [22:0]     mem [FDEPTH];

  logic [CW-1:0]   cnt_val  [NCH];
  logic [CW-1:0]   cnt_next [NCH];
  logic [NCH-1:0]  at_stop;

  logic            req, pop_edge, pop, wr_en, empty, full, stop, cnt_clr, cnt_inc;
  logic [AW:0]     occ;
  logic [8:0]      occ9;
  logic [7:0]      occ_sat;
  logic [23:0]     timer_next;
  logic [22:0]     wr_data;

  assign req        = (Address == MYAD) && Read;
  assign pop_edge   = req && !req_d_reg;
  assign occ        = wr_ptr_reg - rd_ptr_reg;
  assign occ9       = 9'(occ);
  assign occ_sat    = occ9[8] ? 8'hFF : occ9[7:0];
  assign empty      = (occ == '0);
  assign full       = (occ == FULLV);
  assign pop        = pop_edge && !empty && !abort;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_en      = !abort && (state_reg == DUMP) && (!full || pop);
  assign wr_data    = {7'(ch_reg), 16'(cnt_val[ch_reg])};
  assign timer_next = timer_reg + 24'd1;
  assign stop       = mode_reg ? (timer_next == WIN) : (|at_stop);
  assign cnt_clr    = abort || ((state_reg == IDLE) && start) || ((state_reg == DRAIN) && empty);
  assign cnt_inc    = (state_reg == COUNT);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] cnt_reg;
      assign cnt_val[gi]  = cnt_reg;
      assign cnt_next[gi] = (hit[gi] && (cnt_reg != CMAX)) ? cnt_reg + 1'b1 : cnt_reg;
      assign at_stop[gi]  = (cnt_next[gi] >= STOPV);
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)         cnt_reg <= '0;
        else if (cnt_clr) cnt_reg <= '0;
        else if (cnt_inc) cnt_reg <= cnt_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      mode_reg   <= 1'b0;
      timer_reg  <= '0;
      ch_reg     <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      req_d_reg  <= 1'b0;
      ack_reg    <= 1'b0;
      done_reg   <= 1'b0;
      word_reg   <= '0;
    end else if (abort) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      ch_reg     <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      req_d_reg  <= req;
      ack_reg    <= 1'b0;
      done_reg   <= 1'b0;
      word_reg   <= '0;
    end else begin
      req_d_reg <= req;
      ack_reg   <= pop_edge;
      done_reg  <= 1'b0;
      if (pop_edge) word_reg <= empty ? 32'd0 : {1'b1, occ_sat, mem[rd_ptr_reg[AW-1:0]]};
      if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en)    wr_ptr_reg <= wr_ptr_reg + 1'b1;
      case (state_reg)
        IDLE: if (start) begin
          state_reg <= COUNT;
          mode_reg  <= mode;
          timer_reg <= '0;
        end
        COUNT: begin
          timer_reg <= timer_next;
          ch_reg    <= '0;
          if (stop) state_reg <= DUMP;
        end
        DUMP: if (wr_en) begin
          if (ch_reg == LASTCH) state_reg <= DRAIN;
          else                  ch_reg    <= ch_reg + 1'b1;
        end
        DRAIN: if (empty) begin
          state_reg <= IDLE;
          done_reg  <= 1'b1;
          timer_reg <= '0;
          ch_reg    <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DataOut = req ? word_reg : 32'd0;
  assign ack     = ack_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;

endmodule

// File: tb/tb_hit_histogram.sv
// Scoreboard bench: a threshold/window-stopped instance with a 4-deep FIFO and
// a 4-bit-counter instance for saturation, sharing stimulus.
module tb_hit_histogram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [31:0] hit = '0;
  logic [7:0]  Address = 8'h00;
  logic        Read = 1'b0;
  logic [31:0] dout_a, dout_b;
  logic        ack_a, ack_b, busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  hit_histogram #(.MYAD(8'hC4), .NCH(32), .CW(16), .MAXCNT(16'd5), .WINDOW(100), .FDEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .mode(mode), .hit(hit),
    .Address(Address), .Read(Read), .DataOut(dout_a), .ack(ack_a), .busy(busy_a), .done(done_a));

  hit_histogram #(.MYAD(8'hC4), .NCH(32), .CW(4), .MAXCNT(16'd15), .WINDOW(100), .FDEPTH(64)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .mode(mode), .hit(hit),
    .Address(Address), .Read(Read), .DataOut(dout_b), .ack(ack_b), .busy(busy_b), .done(done_b));

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected read word when the FIFO sat full (stalled dump) before the reads began.
  function automatic logic [31:0] exp_word(input int ch, input int cnt, input int fd);
    int occ;
    occ = (32 - ch < fd) ? 32 - ch : fd;
    return {1'b1, 8'(occ), 7'(ch), 16'(cnt)};
  endfunction

  task automatic push_run(input int cnts [32], input int fd);
    for (int c = 0; c < 32; c++) sb_q.push_back(exp_word(c, cnts[c], fd));
  endtask

  task automatic do_read(input bit sel_b, input int hold, output int acks, output logic [31:0] word);
    @(negedge clk);
    Address = 8'hC4; Read = 1'b1; acks = 0; word = '0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (sel_b ? ack_b : ack_a) begin
        acks++;
        word = sel_b ? dout_b : dout_a;
      end
    end
    Read = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout_a, ack_a, busy_a, done_a} !== 35'd0 || {dout_b, ack_b, busy_b, done_b} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h/%b%b%b b=%h/%b%b%b expected all zero",
               dout_a, ack_a, busy_a, done_a, dout_b, ack_b, busy_b, done_b);
    end
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_empty_read;
    int acks; logic [31:0] w;
    do_read(1'b0, 2, acks, w);
    checks++;
    if (acks !== 1 || w !== 32'd0) begin
      errors++;
      $display("FAIL empty_read: got acks=%0d word=%h expected acks=1 word=00000000", acks, w);
    end
    $display("empty read acks=%0d word=%h", acks, w);
  endtask

  task automatic test_mode0;
    int mc [32]; int c; int acks; int d0; logic [31:0] w, e;
    mc = '{default: 0};
    @(negedge clk); mode = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; mode = 1'b1;
    c = 0;
    while (mc[3] < 5 && c < 50) begin
      c++;
      hit = '0; hit[3] = 1'b1; mc[3]++;
      if (c % 2 == 1) begin hit[7] = 1'b1; mc[7]++; end
      @(negedge clk);
    end
    hit = '0; mode = 1'b0;
    push_run(mc, 4);
    start_a = 1'b1; repeat (3) @(negedge clk); start_a = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL mode0_busy: got %b expected 1", busy_a); end
    d0 = done_cnt_a;
    for (int k = 0; k < 32; k++) begin
      do_read(1'b0, 1, acks, w);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (acks !== 1 || w !== e) begin
        errors++;
        $display("FAIL mode0_read%0d: got acks=%0d word=%h expected acks=1 word=%h", k, acks, w, e);
      end
      $display("mode0 read %0d word=%h", k, w);
      if (k < 31) begin
        checks++;
        if (done_cnt_a !== d0) begin errors++; $display("FAIL mode0_early_done: got %0d expected %0d", done_cnt_a, d0); end
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt_a !== d0 + 1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL mode0_done: got pulses=%0d busy=%b expected pulses=1 busy=0", done_cnt_a - d0, busy_a);
    end
  endtask

  task automatic test_mode1;
    int mc [32]; int acks; logic [31:0] w, e;
    mc = '{default: 0}; mc[0] = 100;
    @(negedge clk); mode = 1'b1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; hit = 32'd1;
    push_run(mc, 4);
    do_read(1'b0, 1, acks, w);
    checks++;
    if (acks !== 1 || w !== 32'd0) begin
      errors++;
      $display("FAIL mode1_count_read: got acks=%0d word=%h expected acks=1 word=00000000", acks, w);
    end
    repeat (150) @(negedge clk);
    hit = '0;
    for (int k = 0; k < 32; k++) begin
      do_read(1'b0, 1, acks, w);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (acks !== 1 || w !== e) begin
        errors++;
        $display("FAIL mode1_read%0d: got acks=%0d word=%h expected acks=1 word=%h", k, acks, w, e);
      end
      $display("mode1 read %0d word=%h", k, w);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_saturate;
    int mc [32]; int acks; int d0; logic [31:0] w, e;
    mc = '{default: 15};
    @(negedge clk); mode = 1'b1; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; hit = '1;
    push_run(mc, 64);
    repeat (150) @(negedge clk);
    hit = '0;
    d0 = done_cnt_b;
    for (int k = 0; k < 32; k++) begin
      do_read(1'b1, 1, acks, w);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (acks !== 1 || w !== e) begin
        errors++;
        $display("FAIL sat_read%0d: got acks=%0d word=%h expected acks=1 word=%h", k, acks, w, e);
      end
      $display("sat read %0d word=%h", k, w);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt_b !== d0 + 1) begin errors++; $display("FAIL sat_done: got %0d pulses expected 1", done_cnt_b - d0); end
  endtask

  task automatic test_held_read;
    int mc [32]; int acks; logic [31:0] w, e;
    mc = '{default: 0}; mc[5] = 5;
    @(negedge clk); mode = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; hit = 32'h20;
    repeat (5) @(negedge clk);
    hit = '0;
    push_run(mc, 4);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      do_read(1'b0, (k == 0) ? 10 : 1, acks, w);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (acks !== 1 || w !== e) begin
        errors++;
        $display("FAIL held_read%0d: got acks=%0d word=%h expected acks=1 word=%h", k, acks, w, e);
      end
      $display("held run read %0d acks=%0d word=%h", k, acks, w);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_abort;
    int acks; int d0; logic [31:0] w;
    @(negedge clk); mode = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; hit = 32'h20;
    repeat (5) @(negedge clk);
    hit = '0;
    repeat (10) @(negedge clk);
    d0 = done_cnt_a;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
    do_read(1'b0, 1, acks, w);
    checks++;
    if (acks !== 1 || w !== 32'd0) begin
      errors++;
      $display("FAIL abort_read: got acks=%0d word=%h expected acks=1 word=00000000", acks, w);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt_a !== d0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt_a - d0); end
    $display("abort busy=%b read word=%h", busy_a, w);
  endtask

  task automatic test_async_reset;
    @(negedge clk); mode = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; hit = 32'h8;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({dout_a, ack_a, busy_a, done_a} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b%b%b expected all zero", dout_a, ack_a, busy_a, done_a);
    end
    hit = '0;
    @(negedge clk); rst = 1'b1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_release_start: got busy=%b expected 1", busy_a); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    $display("async reset check busy=%b", busy_a);
  endtask

  initial begin
    test_reset;
    test_empty_read;
    test_mode0;
    test_mode1;
    test_saturate;
    test_held_read;
    test_abort;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
